// File: rtl/instrumented_adder_brent_wrapper_if.sv
// LA/IO bus bundle for the instrumented Brent-Kung adder; the master side drives
// the project select, LA inputs and IO inputs, the slave side returns LA/IO outputs.
interface instrumented_adder_brent_wrapper_if;
    logic        active;
    logic [31:0] la1_data_in;
    logic [31:0] la2_data_in;
    logic [31:0] la3_data_in;
    logic [31:0] la1_oenb;
    logic [31:0] la2_oenb;
    logic [31:0] la3_oenb;
    logic [31:0] la1_data_out;
    logic [31:0] la2_data_out;
    logic [31:0] la3_data_out;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    modport master (
        output active, la1_data_in, la2_data_in, la3_data_in,
        output la1_oenb, la2_oenb, la3_oenb, io_in,
        input  la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
    );

    modport slave (
        input  active, la1_data_in, la2_data_in, la3_data_in,
        input  la1_oenb, la2_oenb, la3_oenb, io_in,
        output la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
    );
endinterface

// File: rtl/instrumented_adder_brent_wrapper.sv
// 32-bit Brent-Kung adder with LA-programmed operands, ring feedback and output masking.
// Optional macro BRENT_TRISTATE_EN: outputs float ('z) instead of parking when not active.
module instrumented_adder_brent_wrapper #(
    parameter int WIDTH = 32
) (
    input logic                              wb_clk_i,
    input logic                              rst_n,
    instrumented_adder_brent_wrapper_if.slave bus
);

    localparam int LOG2 = $clog2(WIDTH);

    logic [WIDTH-1:0] a_input;
    logic [WIDTH-1:0] b_input;
    logic [WIDTH-1:0] a_input_ext_bit_b;
    logic [WIDTH-1:0] a_input_ring_bit_b;
    logic [WIDTH-1:0] s_output_bit_b;
    logic [WIDTH-1:0] sum_q;
    logic             chain_out;
    logic [31:0]      cycle_count;

    logic             ctrl_valid;
    logic             wr;
    logic             run;
    logic [2:0]       sel;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen_pre;
    logic [WIDTH-1:0] prop_pre;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign ctrl_valid = (bus.la3_oenb[4:0] == 5'd0);
    assign wr         = ctrl_valid & bus.la3_data_in[0];
    assign sel        = bus.la3_data_in[3:1];
    assign run        = ctrl_valid & bus.la3_data_in[4];

    // External operand wins over ring feedback; both masks are active-low.
    assign a_eff = (a_input & ~a_input_ext_bit_b)
                 | (sum_q & a_input_ext_bit_b & ~a_input_ring_bit_b);

    // Prefix tree evaluated in place: no node is both read and written within a level.
    always_comb begin
        prop     = a_eff ^ b_input;
        gen_pre  = a_eff & b_input;
        prop_pre = prop;
        for (int l = 0; l < LOG2; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    gen_pre[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[i - (1 << l)]);
                    prop_pre[i] = prop_pre[i] & prop_pre[i - (1 << l)];
                end
            end
        end
        for (int l = LOG2 - 2; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
                    gen_pre[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[i - (1 << l)]);
                    prop_pre[i] = prop_pre[i] & prop_pre[i - (1 << l)];
                end
            end
        end
        sum  = prop ^ {gen_pre[WIDTH-2:0], 1'b0};
        cout = gen_pre[WIDTH-1];
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            a_input            <= '0;
            b_input            <= '0;
            a_input_ext_bit_b  <= '1;
            a_input_ring_bit_b <= '1;
            s_output_bit_b     <= '0;
            sum_q              <= '0;
            chain_out          <= 1'b0;
            cycle_count        <= '0;
        end else begin
            if (wr) begin
                case (sel)
                    3'd0:    a_input            <= bus.la1_data_in;
                    3'd1:    b_input            <= bus.la2_data_in;
                    3'd2:    a_input_ext_bit_b  <= bus.la1_data_in;
                    3'd3:    a_input_ring_bit_b <= bus.la1_data_in;
                    3'd4:    s_output_bit_b     <= bus.la1_data_in;
                    default: ;
                endcase
            end
            if (run) begin
                sum_q       <= sum;
                chain_out   <= cout;
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    logic [31:0] la1_raw;
    logic [31:0] la2_raw;
    logic [31:0] la3_raw;
    logic [37:0] io_out_raw;
    logic [37:0] io_oeb_raw;

    assign la1_raw    = sum_q & ~s_output_bit_b;
    assign la2_raw    = cycle_count;
    assign la3_raw    = {31'b0, chain_out};
    assign io_out_raw = {sum_q[27:0], chain_out, 9'b0};
    assign io_oeb_raw = {29'b0, 9'h1FF};

`ifdef BRENT_TRISTATE_EN
    assign bus.la1_data_out = bus.active ? la1_raw    : 'z;
    assign bus.la2_data_out = bus.active ? la2_raw    : 'z;
    assign bus.la3_data_out = bus.active ? la3_raw    : 'z;
    assign bus.io_out       = bus.active ? io_out_raw : 'z;
    assign bus.io_oeb       = bus.active ? io_oeb_raw : 'z;
`else
    assign bus.la1_data_out = bus.active ? la1_raw    : '0;
    assign bus.la2_data_out = bus.active ? la2_raw    : '0;
    assign bus.la3_data_out = bus.active ? la3_raw    : '0;
    assign bus.io_out       = bus.active ? io_out_raw : '0;
    assign bus.io_oeb       = bus.active ? io_oeb_raw : '1;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.la1_oenb, bus.la2_oenb, bus.la3_oenb[31:5],
                           bus.la3_data_in[31:5], bus.io_in, prop_pre};

endmodule

// File: tb/tb_instrumented_adder_brent_wrapper.sv
// Scoreboard bench for instrumented_adder_brent_wrapper: reference 33-bit add and register model.
module tb_instrumented_adder_brent_wrapper;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instrumented_adder_brent_wrapper_if bus ();

    instrumented_adder_brent_wrapper dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] a_m, b_m, ext_m, ring_m, mask_m, sum_m, cnt_m;
    logic        cout_m;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic [31:0] cnt;
        logic [31:0] mask;
    } exp_t;
    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        a_m = '0; b_m = '0; ext_m = '1; ring_m = '1; mask_m = '0;
        sum_m = '0; cout_m = 1'b0; cnt_m = '0;
        sb.delete();
    endtask

    // Advances the reference by one run cycle and queues what the DUT must show afterwards.
    task automatic model_run();
        logic [31:0] a_eff;
        logic [32:0] full;
        a_eff = (a_m & ~ext_m) | (sum_m & ext_m & ~ring_m);
        full  = {1'b0, a_eff} + {1'b0, b_m};
        sum_m  = full[31:0];
        cout_m = full[32];
        cnt_m  = cnt_m + 32'd1;
        sb.push_back('{sum: sum_m, cout: cout_m, cnt: cnt_m, mask: mask_m});
    endtask

    task automatic model_write(input logic [2:0] sel, input logic [31:0] d);
        case (sel)
            3'd0: a_m = d;
            3'd1: b_m = d;
            3'd2: ext_m = d;
            3'd3: ring_m = d;
            3'd4: mask_m = d;
            default: ;
        endcase
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [31:0] d);
        bus.la1_data_in = d;
        bus.la2_data_in = d;
        bus.la3_data_in = {27'b0, 1'b0, sel, 1'b1};
        tick();
        model_write(sel, d);
        bus.la3_data_in = '0;
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            bus.la3_data_in = 32'h10;
            model_run();
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.la1_data_out !== (e.sum & ~e.mask)) begin
                errors++;
                $display("FAIL run_sum: got %h expected %h", bus.la1_data_out, e.sum & ~e.mask);
            end
            checks++;
            if (bus.la3_data_out !== {31'b0, e.cout}) begin
                errors++;
                $display("FAIL run_cout: got %h expected %h", bus.la3_data_out, {31'b0, e.cout});
            end
            checks++;
            if (bus.la2_data_out !== e.cnt) begin
                errors++;
                $display("FAIL run_count: got %h expected %h", bus.la2_data_out, e.cnt);
            end
        end
        bus.la3_data_in = '0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.la1_data_out, bus.la2_data_out, bus.la3_data_out} !== 96'd0) begin
            errors++;
            $display("FAIL reset_la: got %h %h %h expected 0", bus.la1_data_out, bus.la2_data_out, bus.la3_data_out);
        end
        checks++;
        if (bus.io_out !== 38'd0 || bus.io_oeb !== 38'h00000001FF) begin
            errors++;
            $display("FAIL reset_io: got io_out=%h io_oeb=%h expected 0 / 00000001ff", bus.io_out, bus.io_oeb);
        end
    endtask

    task automatic test_basic_add();
        write_reg(3'd0, 32'd5);
        write_reg(3'd1, 32'd7);
        write_reg(3'd2, 32'd0);
        run_cycles(1);
        checks++;
        if (bus.la1_data_out !== 32'd12 || bus.la2_data_out !== 32'd1) begin
            errors++;
            $display("FAIL basic_add: got sum=%h cnt=%h expected 0000000c / 00000001", bus.la1_data_out, bus.la2_data_out);
        end
    endtask

    task automatic test_carry();
        write_reg(3'd0, 32'hFFFFFFFF);
        write_reg(3'd1, 32'd1);
        run_cycles(1);
        checks++;
        if (bus.io_out !== {sum_m[27:0], cout_m, 9'b0} || bus.io_out[9] !== 1'b1) begin
            errors++;
            $display("FAIL carry_io: got %h expected %h", bus.io_out, {sum_m[27:0], 1'b1, 9'b0});
        end
    endtask

    task automatic test_ctrl_gate();
        bus.la3_oenb = 32'h1;
        bus.la1_data_in = 32'h55;
        bus.la3_data_in = {27'b0, 1'b1, 3'd0, 1'b1};
        tick();
        bus.la3_oenb = '0;
        bus.la3_data_in = '0;
        write_reg(3'd5, 32'hDEADBEEF);
        run_cycles(2);
    endtask

    task automatic test_write_run_same_cycle();
        exp_t e;
        bus.la2_data_in = 32'd100;
        bus.la3_data_in = {27'b0, 1'b1, 3'd1, 1'b1};
        model_run();
        tick();
        b_m = 32'd100;
        bus.la3_data_in = '0;
        e = sb.pop_front();
        checks++;
        if (bus.la1_data_out !== (e.sum & ~e.mask)) begin
            errors++;
            $display("FAIL wr_run_same: got %h expected %h", bus.la1_data_out, e.sum & ~e.mask);
        end
        run_cycles(1);
    endtask

    task automatic test_ring();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        write_reg(3'd3, 32'd0);
        write_reg(3'd1, 32'd1);
        run_cycles(10);
        checks++;
        if (bus.la1_data_out !== 32'd10 || bus.la2_data_out !== 32'd10) begin
            errors++;
            $display("FAIL ring: got sum=%h cnt=%h expected 0000000a / 0000000a", bus.la1_data_out, bus.la2_data_out);
        end
    endtask

    task automatic test_mask();
        write_reg(3'd2, 32'd0);
        write_reg(3'd0, 32'h12345678);
        write_reg(3'd1, 32'd0);
        run_cycles(1);
        write_reg(3'd4, 32'hFFFF0000);
        checks++;
        if (bus.la1_data_out !== 32'h00005678) begin
            errors++;
            $display("FAIL mask: got %h expected 00005678", bus.la1_data_out);
        end
        write_reg(3'd4, 32'd0);
    endtask

    task automatic test_active();
        bus.active = 1'b0;
        bus.la3_data_in = 32'h10;
        model_run();
        void'(sb.pop_front());
        tick();
        bus.la3_data_in = '0;
`ifdef BRENT_TRISTATE_EN
        checks++;
        if (bus.la1_data_out !== 32'hzzzzzzzz || bus.io_oeb !== {38{1'bz}}) begin
            errors++;
            $display("FAIL inactive: got la1=%h io_oeb=%h expected z", bus.la1_data_out, bus.io_oeb);
        end
`else
        checks++;
        if ({bus.la1_data_out, bus.la2_data_out, bus.la3_data_out} !== 96'd0 || bus.io_out !== 38'd0) begin
            errors++;
            $display("FAIL inactive_out: got %h %h %h io=%h expected 0", bus.la1_data_out, bus.la2_data_out, bus.la3_data_out, bus.io_out);
        end
        checks++;
        if (bus.io_oeb !== {38{1'b1}}) begin
            errors++;
            $display("FAIL inactive_oeb: got %h expected 3fffffffff", bus.io_oeb);
        end
`endif
        bus.active = 1'b1;
        #1;
        checks++;
        if (bus.la2_data_out !== cnt_m || bus.la1_data_out !== sum_m) begin
            errors++;
            $display("FAIL inactive_state: got cnt=%h sum=%h expected %h %h", bus.la2_data_out, bus.la1_data_out, cnt_m, sum_m);
        end
    endtask

    task automatic test_reset_mid_run();
        run_cycles(2);
        bus.la3_data_in = 32'h10;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.la1_data_out, bus.la2_data_out, bus.la3_data_out} !== 96'd0 || bus.io_out !== 38'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h %h %h io=%h expected 0", bus.la1_data_out, bus.la2_data_out, bus.la3_data_out, bus.io_out);
        end
        tick();
        bus.la3_data_in = '0;
        #3;
        rst_n = 1'b1;
        model_reset();
        #1;
        write_reg(3'd1, 32'd3);
        run_cycles(2);
        checks++;
        if (bus.la1_data_out !== 32'd3 || bus.la2_data_out !== 32'd2) begin
            errors++;
            $display("FAIL post_reset: got sum=%h cnt=%h expected 00000003 / 00000002", bus.la1_data_out, bus.la2_data_out);
        end
    endtask

    task automatic test_random();
        write_reg(3'd2, 32'd0);
        write_reg(3'd4, 32'd0);
        for (int v = 0; v < 1000; v++) begin
            write_reg(3'd0, $urandom);
            write_reg(3'd1, (v % 10 == 0) ? ~a_m : $urandom);
            run_cycles(1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.active = 1'b1;
        bus.la1_data_in = '0;
        bus.la2_data_in = '0;
        bus.la3_data_in = '0;
        bus.la1_oenb = '1;
        bus.la2_oenb = '1;
        bus.la3_oenb = '0;
        bus.io_in = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_basic_add();
        test_carry();
        test_ctrl_gate();
        test_write_run_same_cycle();
        test_ring();
        test_mask();
        test_active();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
